// File: rtl/noc_net_iface_pkg.sv
// Shared types for the PE <-> router network interface.
//   tx_state_t : TX 4-phase master handshake states
//   rx_state_t : RX 4-phase slave handshake states
//   pkt_width  : header + payload width of one packet
package noc_net_iface_pkg;

   localparam int DEF_PAYLOAD = 32;
   localparam int DEF_X_BITS  = 1;
   localparam int DEF_Y_BITS  = 1;

   typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_REL} tx_state_t;
   typedef enum logic       {RX_IDLE, RX_ACK}         rx_state_t;

   function automatic int pkt_width(int payload, int x_bits, int y_bits);
      return payload + x_bits + y_bits;
   endfunction

endpackage

// File: rtl/noc_net_iface_if.sv
// Bundle of all non-clock signals of the network interface.
//   PE side    : tx_valid/tx_ready/tx_dst_x/tx_dst_y/tx_payload, rx_valid/rx_ready/rx_packet
//   Router side: net_req_o/net_data_o/net_ack_i (to proc_input),
//                net_req_i/net_data_i/net_ack_o (from proc_output)
//   slave  : view of the interface block itself
//   master : view of the environment (PE + router)
interface noc_net_iface_if
   import noc_net_iface_pkg::*;
#(
   parameter int PAYLOAD = DEF_PAYLOAD,
   parameter int X_BITS  = DEF_X_BITS,
   parameter int Y_BITS  = DEF_Y_BITS
);
   localparam int PKT_W = pkt_width(PAYLOAD, X_BITS, Y_BITS);

   logic               tx_valid;
   logic               tx_ready;
   logic [X_BITS-1:0]  tx_dst_x;
   logic [Y_BITS-1:0]  tx_dst_y;
   logic [PAYLOAD-1:0] tx_payload;
   logic               rx_valid;
   logic               rx_ready;
   logic [PKT_W-1:0]   rx_packet;
   logic               net_req_o;
   logic [PKT_W-1:0]   net_data_o;
   logic               net_ack_i;
   logic               net_req_i;
   logic [PKT_W-1:0]   net_data_i;
   logic               net_ack_o;

   modport slave (
      input  tx_valid, tx_dst_x, tx_dst_y, tx_payload, rx_ready,
             net_ack_i, net_req_i, net_data_i,
      output tx_ready, rx_valid, rx_packet, net_req_o, net_data_o, net_ack_o
   );

   modport master (
      output tx_valid, tx_dst_x, tx_dst_y, tx_payload, rx_ready,
             net_ack_i, net_req_i, net_data_i,
      input  tx_ready, rx_valid, rx_packet, net_req_o, net_data_o, net_ack_o
   );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with occupancy count.
//   push/din   : write when push && !full
//   pop/dout   : dout is the head (combinational read); removed when pop && !empty
//   full/empty : derived from count
//   count      : $clog2(DEPTH)+1 bits, 0..DEPTH
module noc_sync_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             do_push, do_pop;

   // Boundary cases fall out of the gating: push on full and pop on empty are dropped.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/noc_net_iface.sv
// Network interface between a synchronous PE and the proc port of a self-timed router.
//   clk, rst : single clock, synchronous active-low reset (shared with the router)
//   bus      : noc_net_iface_if.slave
//     TX: PE words {dst_x,dst_y,payload} -> TX FIFO -> 4-phase req/ack to router proc_input
//     RX: router proc_output 4-phase req/ack -> RX FIFO -> PE valid/ready
// Asynchronous req/ack inputs pass through SYNC_STAGES-deep flop chains.
module noc_net_iface
   import noc_net_iface_pkg::*;
#(
   parameter int PAYLOAD     = DEF_PAYLOAD,
   parameter int X_BITS      = DEF_X_BITS,
   parameter int Y_BITS      = DEF_Y_BITS,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   noc_net_iface_if.slave   bus
);
   localparam int PKT_W = pkt_width(PAYLOAD, X_BITS, Y_BITS);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   // ---------------- synchronizers ----------------
   logic [SYNC_STAGES-1:0] ack_sync, req_sync;
   logic                   ack_s, req_s;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ack_sync <= '0;
         req_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.net_ack_i};
         req_sync <= {req_sync[SYNC_STAGES-2:0], bus.net_req_i};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];
   assign req_s = req_sync[SYNC_STAGES-1];

   // ---------------- TX path ----------------
   logic             tx_push, tx_pop, tx_full, tx_empty;
   logic [PKT_W-1:0] tx_head;
   logic [CW-1:0]    tx_cnt;
   tx_state_t        tx_state, tx_nxt;
   logic             req_q, req_nxt;
   logic [PKT_W-1:0] data_q;

   assign tx_push = bus.tx_valid && !tx_full;

   noc_sync_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   ({bus.tx_dst_x, bus.tx_dst_y, bus.tx_payload}),
      .pop   (tx_pop),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_cnt)
   );

   always_comb begin
      tx_nxt  = tx_state;
      req_nxt = req_q;
      tx_pop  = 1'b0;
      case (tx_state)
         TX_IDLE: if (!tx_empty) begin
            tx_pop  = 1'b1;
            req_nxt = 1'b1;
            tx_nxt  = TX_REQ;
         end
         TX_REQ: if (ack_s) begin
            req_nxt = 1'b0;
            tx_nxt  = TX_REL;
         end
         TX_REL: if (!ack_s) tx_nxt = TX_IDLE;
         default: begin
            req_nxt = 1'b0;
            tx_nxt  = TX_IDLE;
         end
      endcase
   end

   // data_q loads only when leaving IDLE, so it is bundled-stable for the whole handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state <= TX_IDLE;
         req_q    <= 1'b0;
         data_q   <= '0;
      end else begin
         tx_state <= tx_nxt;
         req_q    <= req_nxt;
         if (tx_pop) data_q <= tx_head;
      end
   end

   // ---------------- RX path ----------------
   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic [CW-1:0]    rx_cnt;
   rx_state_t        rx_state, rx_nxt;
   logic             ack_q, ack_nxt;

   assign rx_pop = bus.rx_ready && !rx_empty;

   noc_sync_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .din   (bus.net_data_i),
      .pop   (rx_pop),
      .dout  (bus.rx_packet),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_cnt)
   );

   // A full RX FIFO simply withholds ack: the router stalls, nothing is lost.
   always_comb begin
      rx_nxt  = rx_state;
      ack_nxt = ack_q;
      rx_push = 1'b0;
      case (rx_state)
         RX_IDLE: if (req_s && !rx_full) begin
            rx_push = 1'b1;
            ack_nxt = 1'b1;
            rx_nxt  = RX_ACK;
         end
         RX_ACK: if (!req_s) begin
            ack_nxt = 1'b0;
            rx_nxt  = RX_IDLE;
         end
         default: begin
            ack_nxt = 1'b0;
            rx_nxt  = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state <= RX_IDLE;
         ack_q    <= 1'b0;
      end else begin
         rx_state <= rx_nxt;
         ack_q    <= ack_nxt;
      end
   end

   // Occupancy counts are kept for debug visibility only.
   logic cnt_unused;
   assign cnt_unused = ^{tx_cnt, rx_cnt};

   // ---------------- outputs ----------------
   assign bus.tx_ready   = !tx_full;
   assign bus.rx_valid   = !rx_empty;
   assign bus.net_req_o  = req_q;
   assign bus.net_data_o = data_q;
   assign bus.net_ack_o  = ack_q;

endmodule

// File: tb/tb_noc_net_iface.sv
module tb_noc_net_iface;
   import noc_net_iface_pkg::*;

   localparam int PAYLOAD = 32;
   localparam int XB      = 1;
   localparam int YB      = 1;
   localparam int DEPTH   = 4;
   localparam int SS      = 2;
   localparam int PW      = PAYLOAD + XB + YB;
   localparam logic [PW-1:0] PKT_DB = 34'h2_DEADBEEF;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   noc_net_iface_if #(.PAYLOAD(PAYLOAD), .X_BITS(XB), .Y_BITS(YB)) bus();

   noc_net_iface #(
      .PAYLOAD(PAYLOAD), .X_BITS(XB), .Y_BITS(YB),
      .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic auto_ack = 1'b0, ack_auto = 1'b0, ack_man = 1'b0;
   logic rx_auto  = 1'b0, rdy_auto = 1'b0, rdy_man = 1'b0;
   logic rnd_dly  = 1'b0, rx_rnd   = 1'b0;

   assign bus.net_ack_i = auto_ack ? ack_auto : ack_man;
   assign bus.rx_ready  = rx_auto  ? rdy_auto : rdy_man;

   int n_chk = 0, n_pass = 0, viol = 0, rx_sent = 0;
   logic [PW-1:0] txq[$], rxexp[$], rxsrc[$];

   typedef struct {
      logic          vld;
      logic          ack;
      logic          req;
      logic          rdy;
      logic [1:0]    st;
      logic [PW-1:0] data;
   } vec_t;
   vec_t tv[8];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic timeout(string name);
      n_chk++;
      $display("FAIL %s: timed out waiting for handshake", name);
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_tx(logic [XB-1:0] x, logic [YB-1:0] y, logic [PAYLOAD-1:0] pl);
      bus.tx_dst_x   = x;
      bus.tx_dst_y   = y;
      bus.tx_payload = pl;
      bus.tx_valid   = 1'b1;
      for (int k = 0; k < 500 && !bus.tx_ready; k++) tick();
      if (!bus.tx_ready) begin
         timeout("tx_accept");
         bus.tx_valid = 1'b0;
         return;
      end
      txq.push_back({x, y, pl});
      tick();
      bus.tx_valid = 1'b0;
   endtask

   // router proc_input: acks TX packets and checks them against the scoreboard
   initial begin : tx_sink
      int d;
      forever begin
         tick();
         if (auto_ack && bus.net_req_o && !ack_auto) begin
            if (txq.size() == 0) begin
               n_chk++;
               $display("FAIL tx_extra: got %0h expected no packet", bus.net_data_o);
            end else begin
               chk("tx_pkt", 64'(bus.net_data_o), 64'(txq.pop_front()));
            end
            d = rnd_dly ? int'($urandom_range(0, 5)) : 0;
            tick(d);
            ack_auto = 1'b1;
            for (int k = 0; k < 200 && bus.net_req_o; k++) tick();
            if (bus.net_req_o) timeout("tx_req_fall");
            d = rnd_dly ? int'($urandom_range(0, 5)) : 0;
            tick(d);
            ack_auto = 1'b0;
         end
      end
   end

   // router proc_output: sends queued packets, expected copy pushed as each is driven
   initial begin : rx_src
      logic [PW-1:0] p;
      int d;
      bus.net_req_i  = 1'b0;
      bus.net_data_i = '0;
      forever begin
         tick();
         if (rxsrc.size() > 0) begin
            p = rxsrc.pop_front();
            rxexp.push_back(p);
            bus.net_data_i = p;
            d = rnd_dly ? int'($urandom_range(0, 5)) : 0;
            tick(d + 1);
            bus.net_req_i = 1'b1;
            for (int k = 0; k < 2000 && !bus.net_ack_o; k++) tick();
            if (!bus.net_ack_o) timeout("rx_ack_rise");
            d = rnd_dly ? int'($urandom_range(0, 5)) : 0;
            tick(d);
            bus.net_req_i = 1'b0;
            for (int k = 0; k < 200 && bus.net_ack_o; k++) tick();
            if (bus.net_ack_o) timeout("rx_ack_fall");
            rx_sent++;
         end
      end
   end

   // PE consumer: pops RX head and compares against the scoreboard
   initial begin : rx_sink
      forever begin
         tick();
         if (rx_auto) begin
            rdy_auto = rx_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdy_auto && bus.rx_valid) begin
               if (rxexp.size() == 0) begin
                  n_chk++;
                  $display("FAIL rx_extra: got %0h expected no packet", bus.rx_packet);
               end else begin
                  chk("rx_pkt", 64'(bus.rx_packet), 64'(rxexp.pop_front()));
               end
            end
         end else begin
            rdy_auto = 1'b0;
         end
      end
   end

   // net_data_o may only change on the edge where net_req_o rises (or under reset)
   initial begin : stab
      logic pr;
      logic [PW-1:0] pd;
      pr = 1'b0;
      pd = '0;
      forever begin
         tick();
         if (rst && bus.net_data_o !== pd && !(bus.net_req_o && !pr)) viol++;
         pr = bus.net_req_o;
         pd = bus.net_data_o;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : main
      tv[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, '0};
      tv[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, PKT_DB};
      tv[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, PKT_DB};
      tv[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, PKT_DB};
      tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, PKT_DB};
      tv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, PKT_DB};
      tv[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, PKT_DB};
      tv[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, PKT_DB};

      bus.tx_valid   = 1'b0;
      bus.tx_dst_x   = '0;
      bus.tx_dst_y   = '0;
      bus.tx_payload = '0;
      rst = 1'b0;
      tick(2);
      chk("rst_tx_ready", 64'(bus.tx_ready), 1);
      chk("rst_rx_valid", 64'(bus.rx_valid), 0);
      chk("rst_req_o", 64'(bus.net_req_o), 0);
      chk("rst_ack_o", 64'(bus.net_ack_o), 0);
      chk("rst_data_o", 64'(bus.net_data_o), 0);
      rst = 1'b1;
      tick();

      // reset in the middle of a TX handshake with RX data buffered
      rxsrc.push_back(34'h1_12345678);
      for (int k = 0; k < 200 && rx_sent < 1; k++) tick();
      if (rx_sent < 1) timeout("t1_rx_fill");
      chk("t1_rx_valid_pre", 64'(bus.rx_valid), 1);
      bus.tx_dst_x   = 1'b0;
      bus.tx_dst_y   = 1'b1;
      bus.tx_payload = 32'h1111_1111;
      bus.tx_valid   = 1'b1;
      tick(2);
      bus.tx_valid = 1'b0;
      chk("t1_req_pre", 64'(bus.net_req_o), 1);
      chk("t1_txcnt_pre", 64'(dut.u_tx_fifo.count), 1);
      rst = 1'b0;
      tick();
      chk("t1_req_o", 64'(bus.net_req_o), 0);
      chk("t1_tx_ready", 64'(bus.tx_ready), 1);
      chk("t1_rx_valid", 64'(bus.rx_valid), 0);
      chk("t1_ack_o", 64'(bus.net_ack_o), 0);
      chk("t1_data_o", 64'(bus.net_data_o), 0);
      chk("t1_txcnt", 64'(dut.u_tx_fifo.count), 0);
      chk("t1_rxcnt", 64'(dut.u_rx_fifo.count), 0);
      tick();
      rst = 1'b1;
      rxexp.delete();
      tick();

      // single TX, cycle by cycle
      bus.tx_dst_x   = 1'b1;
      bus.tx_dst_y   = 1'b0;
      bus.tx_payload = 32'hDEAD_BEEF;
      for (int i = 0; i < 8; i++) begin
         bus.tx_valid = tv[i].vld;
         ack_man      = tv[i].ack;
         tick();
         chk($sformatf("t2_req[%0d]", i), 64'(bus.net_req_o), 64'(tv[i].req));
         chk($sformatf("t2_rdy[%0d]", i), 64'(bus.tx_ready), 64'(tv[i].rdy));
         chk($sformatf("t2_st[%0d]", i), 64'(dut.tx_state), 64'(tv[i].st));
         chk($sformatf("t2_data[%0d]", i), 64'(bus.net_data_o), 64'(tv[i].data));
      end
      bus.tx_valid = 1'b0;

      // TX backpressure: register + 4 FIFO entries
      for (int k = 0; k < 5; k++)
         push_tx(1'(k), 1'(k >> 1), 32'hA000_0000 + 32'(k));
      chk("t3_tx_ready", 64'(bus.tx_ready), 0);
      chk("t3_txcnt", 64'(dut.u_tx_fifo.count), 4);
      chk("t3_req", 64'(bus.net_req_o), 1);
      auto_ack = 1'b1;
      for (int k = 0; k < 500 && txq.size() > 0; k++) tick();
      if (txq.size() > 0) timeout("t3_drain");
      tick(10);
      chk("t3_tx_ready_end", 64'(bus.tx_ready), 1);

      // RX full backpressure
      for (int k = 0; k < 5; k++)
         rxsrc.push_back({2'(k), 32'hB000_0000 + 32'(k)});
      tick(80);
      chk("t4_rxcnt", 64'(dut.u_rx_fifo.count), 4);
      chk("t4_sent", 64'(rx_sent), 5);
      chk("t4_req_held", 64'(bus.net_req_i), 1);
      chk("t4_ack_low", 64'(bus.net_ack_o), 0);
      rdy_man = 1'b1;
      chk("t4_head", 64'(bus.rx_packet), 64'(rxexp[0]));
      void'(rxexp.pop_front());
      tick();
      rdy_man = 1'b0;
      for (int k = 0; k < 200 && rx_sent < 6; k++) tick();
      if (rx_sent < 6) timeout("t4_fifth");
      chk("t4_rxcnt_refill", 64'(dut.u_rx_fifo.count), 4);
      rx_auto = 1'b1;
      for (int k = 0; k < 200 && rxexp.size() > 0; k++) tick();
      if (rxexp.size() > 0) timeout("t4_drain");
      tick(2);
      chk("t4_rx_valid_end", 64'(bus.rx_valid), 0);

      // concurrent random traffic both ways
      rnd_dly = 1'b1;
      rx_rnd  = 1'b1;
      for (int k = 0; k < 8; k++) rxsrc.push_back(34'($urandom) ^ {2'(k), 32'h0});
      for (int k = 0; k < 8; k++) push_tx(1'($urandom), 1'($urandom), $urandom);
      for (int k = 0; k < 5000 && (rx_sent < 14 || rxexp.size() > 0 || txq.size() > 0); k++)
         tick();
      if (rx_sent < 14 || rxexp.size() > 0 || txq.size() > 0) timeout("t5_complete");
      tick(20);
      chk("t5_data_stable", 64'(viol), 0);
      chk("t5_txq_empty", 64'(txq.size()), 0);
      chk("t5_rxq_empty", 64'(rxexp.size()), 0);
      chk("t5_tx_ready", 64'(bus.tx_ready), 1);
      chk("t5_req_idle", 64'(bus.net_req_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
